// File: rtl/p_sweep_capture.sv
// Exhaustive sweep of P = (W & ~Y & Z) ^ (Y & Z) ^ (~X & Y). The captured truth table is checked against EXPECTED.
// Defining P_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module p_sweep_capture #(
    parameter int          SETTLE   = 1,
    parameter logic [15:0] EXPECTED = 16'hA684
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        W,
    output logic        X,
    output logic        Y,
    output logic        Z,
    input  logic        P,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [15:0] mismatch,
    output logic        pass,
    output logic [3:0]  fail_idx
);

    generate
        if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
            $error("p_sweep_capture: SETTLE must be in 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t      state, state_next;
    logic [3:0]  idx;
    logic [7:0]  settle_cnt;
    logic        mis_bit;
    logic        settle_end;
    logic        stop_now;

    // The function inputs come straight from the registered vector index.
    assign {W, X, Y, Z} = idx;
    assign mis_bit      = P ^ EXPECTED[idx];
    assign settle_end   = (settle_cnt == 8'(SETTLE - 1));

`ifdef P_SWEEP_STOP_ON_FAIL_EN
    assign stop_now = (idx == 4'd15) || mis_bit;
`else
    assign stop_now = (idx == 4'd15);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = DRIVE;
            DRIVE:   if (settle_end) state_next = SAMPLE;
            SAMPLE:  state_next = stop_now ? DONE : DRIVE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == DRIVE) || (state == SAMPLE);
        done = (state == DONE);
    end

    // Mismatch bits fill in ascending index order, so an all-zero mask before
    // this sample means the current mismatch is the first one of the sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= 4'd0;
            settle_cnt  <= 8'd0;
            truth_table <= 16'h0000;
            mismatch    <= 16'h0000;
            pass        <= 1'b0;
            fail_idx    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx         <= 4'd0;
                        settle_cnt  <= 8'd0;
                        truth_table <= 16'h0000;
                        mismatch    <= 16'h0000;
                        pass        <= 1'b0;
                        fail_idx    <= 4'd0;
                    end
                end
                DRIVE: begin
                    settle_cnt <= settle_end ? 8'd0 : settle_cnt + 8'd1;
                end
                SAMPLE: begin
                    truth_table[idx] <= P;
                    mismatch[idx]    <= mis_bit;
                    if (mis_bit && (mismatch == 16'h0000)) begin
                        fail_idx <= idx;
                    end
                    if (stop_now) begin
                        pass <= (mismatch == 16'h0000) && !mis_bit;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_p_sweep_capture.sv
// Randomized check of p_sweep_capture: P is driven by a behavioural model with a per-vector fault mask.
// Expected results are derived from that model.
module tb_p_sweep_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        use3;
    logic [15:0] flip;
    int          n_cmp;
    int          n_bad;
    int          cyc;
    int          done_cnt;

    logic        start1, w1, x1, y1, z1, p1, busy1, done1, pass1;
    logic [15:0] tt1, mm1;
    logic [3:0]  fi1;
    logic        start3, w3, x3, y3, z3, p3, busy3, done3, pass3;
    logic [15:0] tt3, mm3;
    logic [3:0]  fi3;

    logic        busy_m, done_m, pass_m;
    logic [15:0] tt_m, mm_m;
    logic [3:0]  fi_m, vec_m;

    function automatic logic model_p(input logic [3:0] v);
        logic w, x, y, z;
        {w, x, y, z} = v;
        return (w & ~y & z) ^ (y & z) ^ (~x & y);
    endfunction

    assign start1 = start & ~use3;
    assign start3 = start & use3;
    assign p1 = model_p({w1, x1, y1, z1}) ^ flip[{w1, x1, y1, z1}];
    assign p3 = model_p({w3, x3, y3, z3}) ^ flip[{w3, x3, y3, z3}];

    assign busy_m = use3 ? busy3 : busy1;
    assign done_m = use3 ? done3 : done1;
    assign pass_m = use3 ? pass3 : pass1;
    assign tt_m   = use3 ? tt3 : tt1;
    assign mm_m   = use3 ? mm3 : mm1;
    assign fi_m   = use3 ? fi3 : fi1;
    assign vec_m  = use3 ? {w3, x3, y3, z3} : {w1, x1, y1, z1};

    p_sweep_capture #(.SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start1),
        .W(w1), .X(x1), .Y(y1), .Z(z1), .P(p1),
        .busy(busy1), .done(done1), .truth_table(tt1), .mismatch(mm1),
        .pass(pass1), .fail_idx(fi1)
    );

    p_sweep_capture #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .W(w3), .X(x3), .Y(y3), .Z(z3), .P(p3),
        .busy(busy3), .done(done3), .truth_table(tt3), .mismatch(mm3),
        .pass(pass3), .fail_idx(fi3)
    );

    always @(posedge clk) cyc++;
    always @(negedge clk) if (done_m) done_cnt++;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full sweep on the selected instance with fault mask f.
    task automatic applyStimulus(input logic sel, input logic [15:0] f, input bit repulse);
        int          settle, n, busy_cycles, vec_err, dc0;
        logic [15:0] exp_tt, exp_mm;
        logic [3:0]  exp_fi;
        logic        exp_pass, pb, found;
        use3   = sel;
        flip   = f;
        settle = sel ? 3 : 1;
        exp_tt = '0; exp_mm = '0; exp_fi = '0; found = 1'b0; n = 16;
        for (int i = 0; i < 16; i++) begin
            if (i < n) begin
                pb        = model_p(4'(i)) ^ f[i];
                exp_tt[i] = pb;
                exp_mm[i] = pb ^ model_p(4'(i));
                if (exp_mm[i] && !found) begin
                    found  = 1'b1;
                    exp_fi = 4'(i);
`ifdef P_SWEEP_STOP_ON_FAIL_EN
                    n = i + 1;
`endif
                end
            end
        end
        exp_pass = !found;
        dc0 = done_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        busy_cycles = 0;
        vec_err = 0;
        while (busy_m && busy_cycles < 400) begin
            if (vec_m !== 4'(busy_cycles / (settle + 1))) vec_err++;
            start = (repulse && busy_cycles == 5);
            busy_cycles++;
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("busy_len", busy_cycles, n * (settle + 1));
        checkOutput("vec_seq_errors", vec_err, 0);
        checkOutput("done_pulse", {31'b0, done_m}, 1);
        checkOutput("pass_at_done", {31'b0, pass_m}, {31'b0, exp_pass});
        @(negedge clk);
        checkOutput("done_width", {31'b0, done_m}, 0);
        checkOutput("table", {16'b0, tt_m}, {16'b0, exp_tt});
        checkOutput("mismatch", {16'b0, mm_m}, {16'b0, exp_mm});
        checkOutput("fail_idx", {28'b0, fi_m}, {28'b0, exp_fi});
        checkOutput("pass_hold", {31'b0, pass_m}, {31'b0, exp_pass});
        checkOutput("vec_hold", {28'b0, vec_m}, n - 1);
        repeat (3) @(negedge clk);
        checkOutput("done_count", done_cnt - dc0, 1);
    endtask

    task automatic waitDone(output int t);
        int k;
        k = 0;
        while (!done_m && k < 200) begin
            @(negedge clk);
            k++;
        end
        checkOutput("done_timeout", {31'b0, done_m}, 1);
        t = cyc;
        @(negedge clk);
    endtask

    initial begin
        int dc0, t1, t2, k;
        n_cmp = 0; n_bad = 0; cyc = 0; done_cnt = 0;
        rst = 1'b1; start = 1'b0; use3 = 1'b0; flip = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", {5'b0, busy1, done1, pass1, fi1, w1, x1, y1, z1, tt1},
                    32'h0);
        checkOutput("reset_mismatch", {16'b0, mm1}, 32'h0);
        checkOutput("reset_state3", {busy3, done3, pass3, fi3, w3, x3, y3, z3, tt3}, 27'h0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 16'hA684, 1'b0);
        applyStimulus(1'b0, 16'h0200, 1'b0);
        for (int r = 0; r < 6; r++) begin
            applyStimulus(1'b0, 16'($urandom & $urandom), 1'b0);
        end
        applyStimulus(1'b0, 16'h0000, 1'b1);

        // Abort a sweep in the middle with reset.
        use3 = 1'b0; flip = '0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 0;
        while ({w1, x1, y1, z1} != 4'd7 && k < 100) begin
            @(negedge clk);
            k++;
        end
        checkOutput("reach_idx7", {28'b0, w1, x1, y1, z1}, 7);
        dc0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midsweep_reset", {5'b0, busy1, done1, pass1, fi1, w1, x1, y1, z1, tt1},
                    32'h0);
        checkOutput("midsweep_reset_mm", {16'b0, mm1}, 32'h0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("no_done_after_abort", done_cnt - dc0, 0);
        applyStimulus(1'b0, 16'h0000, 1'b0);

        // Held start gives back-to-back sweeps.
        use3 = 1'b0; flip = '0;
        @(negedge clk) start = 1'b1;
        waitDone(t1);
        waitDone(t2);
        checkOutput("back_to_back_gap", t2 - t1, 34);
        start = 1'b0;
        repeat (80) @(negedge clk);

        applyStimulus(1'b1, 16'h0000, 1'b0);
        applyStimulus(1'b1, 16'($urandom & $urandom), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
